// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard unit: tracks destination tags of in-flight instructions,
// selects forwarding sources and raises load-use stalls. Define PIPE_HAZARD_FWD_EN to enable forwarding.
module pipe_hazard_ctrl #(
    parameter int STAGES   = 3,
    parameter int REG_AW   = 5,
    parameter int LOAD_RDY = 1,
    parameter int CNT_W    = 16,
    localparam int FW      = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wr,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_ld,
    input  logic              flush,
    output logic              stall,
    output logic [FW-1:0]     fwd_a,
    output logic [FW-1:0]     fwd_b,
    output logic [STAGES-1:0] slot_v,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [STAGES-1:0]             v_q, v_d, ld_q, ld_d;
    logic [STAGES-1:0][REG_AW-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;

    logic [FW-1:0] fa, fb;
    logic          blk_a, blk_b, issue;

    // Scan oldest to youngest so the lowest matching slot is the one kept.
    always_comb begin
        fa    = '0;
        fb    = '0;
        blk_a = 1'b0;
        blk_b = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (id_use_rs && id_rs != '0 && v_q[k] && rd_q[k] == id_rs) begin
                fa = FW'(k + 1);
`ifdef PIPE_HAZARD_FWD_EN
                blk_a = ld_q[k] && (k < LOAD_RDY);
`else
                blk_a = (k < STAGES - 1);
`endif
            end
            if (id_use_rt && id_rt != '0 && v_q[k] && rd_q[k] == id_rt) begin
                fb = FW'(k + 1);
`ifdef PIPE_HAZARD_FWD_EN
                blk_b = ld_q[k] && (k < LOAD_RDY);
`else
                blk_b = (k < STAGES - 1);
`endif
            end
        end
    end

`ifdef PIPE_HAZARD_FWD_EN
    assign fwd_a = fa;
    assign fwd_b = fb;
`else
    // Without forwarding the slot ld bits and match indices only feed the stall decision.
    logic unused_sink;
    assign unused_sink = ^{ld_q, fa, fb};
    assign fwd_a = '0;
    assign fwd_b = '0;
`endif

    assign stall = id_valid && (blk_a || blk_b) && !flush;
    assign issue = id_valid && id_wr && (id_rd != '0) && !stall && !flush;

    always_comb begin
        v_d     = '0;
        ld_d    = '0;
        rd_d    = '0;
        v_d[0]  = issue;
        ld_d[0] = issue & id_ld;
        rd_d[0] = issue ? id_rd : '0;
        for (int k = 1; k < STAGES; k++) begin
            v_d[k]  = v_q[k-1];
            ld_d[k] = ld_q[k-1];
            rd_d[k] = rd_q[k-1];
        end
        cnt_d = cnt_q;
        if (stall && !(&cnt_q))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            ld_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            ld_q  <= ld_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign slot_v    = v_q;
    assign stall_cnt = cnt_q;

endmodule
